// File: rtl/hnd_pkt_receiver.sv
// rtl/hnd_pkt_receiver.sv - handshake packet receiver: sync hunt, Hamming(7,4) header decode, duplicate detect
module hnd_pkt_receiver #(
    parameter int                   SYNC_BITS     = 8,
    parameter logic [SYNC_BITS-1:0] SYNCWORD      = 8'hff,
    parameter int                   ENC_HEAD_BITS = 7
) (
    input  logic clk,
    input  logic rst_l,
    input  logic rx_en,
    input  logic serial_in,
    output logic pkt_valid,
    output logic pkt_err,
    output logic pid,
    output logic seq_num,
    output logic corrected,
    output logic seq_dup
);

    localparam int CW = $clog2(ENC_HEAD_BITS);

    typedef enum logic {HUNT, DATA} state_t;

    state_t                   state_q, state_d;
    logic [SYNC_BITS-1:0]     sync_q, sync_d, sync_shift;
    logic [ENC_HEAD_BITS-2:0] code_q, code_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     pkt_valid_q, pkt_valid_d;
    logic                     pkt_err_q, pkt_err_d;
    logic                     pid_q, pid_d;
    logic                     seq_q, seq_d;
    logic                     corr_q, corr_d;
    logic                     dup_q, dup_d;
    logic                     last_seq_q, last_seq_d;

    // Header decode on the word completed by the current bit; x_k lives at word[7-k]
    logic [ENC_HEAD_BITS-1:0] word, fixed;
    logic [2:0]               syn;
    logic                     hdr_ok;

    always_comb begin
        word   = {code_q, serial_in};
        syn[0] = word[6] ^ word[4] ^ word[2] ^ word[0];
        syn[1] = word[5] ^ word[4] ^ word[1] ^ word[0];
        syn[2] = word[3] ^ word[2] ^ word[1] ^ word[0];
        fixed  = word;
        if (syn != 3'd0) begin
            fixed[3'd7 - syn] = ~word[3'd7 - syn];
        end
        // pid at position 3, seqNum at 5, their complements at 6 and 7
        hdr_ok = (fixed[4] != fixed[1]) && (fixed[2] != fixed[0]);
    end

    assign sync_shift = {sync_q[SYNC_BITS-2:0], serial_in};

    // Next-state: sync hunt, header shift, and result registration on the last header bit
    always_comb begin
        state_d     = state_q;
        sync_d      = sync_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        pkt_valid_d = 1'b0;
        pkt_err_d   = 1'b0;
        corr_d      = 1'b0;
        dup_d       = 1'b0;
        pid_d       = pid_q;
        seq_d       = seq_q;
        last_seq_d  = last_seq_q;
        if (!rx_en) begin
            state_d = HUNT;
            sync_d  = '0;
            code_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    sync_d = sync_shift;
                    if (sync_shift == SYNCWORD) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    code_d = {code_q[ENC_HEAD_BITS-3:0], serial_in};
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(ENC_HEAD_BITS - 1)) begin
                        state_d = HUNT;
                        sync_d  = '0;
                        cnt_d   = '0;
                        corr_d  = (syn != 3'd0);
                        if (hdr_ok) begin
                            pkt_valid_d = 1'b1;
                            pid_d       = fixed[4];
                            seq_d       = fixed[2];
                            dup_d       = (fixed[2] == last_seq_q);
                            last_seq_d  = fixed[2];
                        end else begin
                            pkt_err_d   = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State and output registers; last_seq resets to 1 so a first seq 0 is fresh
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= HUNT;
            sync_q      <= '0;
            code_q      <= '0;
            cnt_q       <= '0;
            pkt_valid_q <= 1'b0;
            pkt_err_q   <= 1'b0;
            pid_q       <= 1'b0;
            seq_q       <= 1'b0;
            corr_q      <= 1'b0;
            dup_q       <= 1'b0;
            last_seq_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_err_q   <= pkt_err_d;
            pid_q       <= pid_d;
            seq_q       <= seq_d;
            corr_q      <= corr_d;
            dup_q       <= dup_d;
            last_seq_q  <= last_seq_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_err   = pkt_err_q;
    assign pid       = pid_q;
    assign seq_num   = seq_q;
    assign corrected = corr_q;
    assign seq_dup   = dup_q;

endmodule

// File: tb/tb_hnd_pkt_receiver.sv
// tb/tb_hnd_pkt_receiver.sv - self-checking bench for hnd_pkt_receiver
module tb_hnd_pkt_receiver;

    logic clk = 1'b0;
    logic rst_l, rx_en, serial_in;
    logic pkt_valid, pkt_err, pid, seq_num, corrected, seq_dup;

    hnd_pkt_receiver dut (
        .clk(clk), .rst_l(rst_l), .rx_en(rx_en), .serial_in(serial_in),
        .pkt_valid(pkt_valid), .pkt_err(pkt_err), .pid(pid), .seq_num(seq_num),
        .corrected(corrected), .seq_dup(seq_dup)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] SYNC = 8'hff;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int prev_pv = -100;
    int last_pv = -100;

    // Reference model: bit windows kept as queues, header decoded by index-XOR syndrome
    bit m_hunt, m_last;
    bit m_valid, m_err, m_pid, m_seq, m_corr, m_dup;
    bit m_win[$];
    bit m_dat[$];

    task automatic clear_win();
        m_win.delete();
        repeat (8) m_win.push_back(1'b0);
    endtask

    task automatic model_reset();
        {m_valid, m_err, m_pid, m_seq, m_corr, m_dup} = '0;
        m_last = 1'b1;
        m_hunt = 1'b1;
        clear_win();
        m_dat.delete();
    endtask

    task automatic model_decode();
        bit x[8];
        int s;
        s = 0;
        for (int k = 1; k <= 7; k++) begin
            x[k] = m_dat[k-1];
            if (x[k]) s = s ^ k;
        end
        if (s != 0) begin
            x[s] = ~x[s];
            m_corr = 1'b1;
        end
        if (x[3] != x[6] && x[5] != x[7]) begin
            m_valid = 1'b1;
            m_pid   = x[3];
            m_seq   = x[5];
            m_dup   = (x[5] == m_last);
            m_last  = x[5];
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input bit b);
        bit match;
        if (!rst) begin
            model_reset();
            return;
        end
        {m_valid, m_err, m_corr, m_dup} = '0;
        if (!en) begin
            m_hunt = 1'b1;
            clear_win();
            m_dat.delete();
            return;
        end
        if (m_hunt) begin
            m_win.push_back(b);
            void'(m_win.pop_front());
            match = 1'b1;
            for (int i = 0; i < 8; i++) if (m_win[i] != SYNC[7-i]) match = 1'b0;
            if (match) begin
                m_hunt = 1'b0;
                m_dat.delete();
            end
        end else begin
            m_dat.push_back(b);
            if (m_dat.size() == 7) begin
                model_decode();
                m_hunt = 1'b1;
                clear_win();
            end
        end
    endtask

    function automatic logic [5:0] dut_out();
        return {pkt_valid, pkt_err, pid, seq_num, corrected, seq_dup};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc_n);
        end
    endtask

    task automatic cyc(input bit b);
        serial_in = b;
        @(posedge clk);
        #1;
        cyc_n++;
        model_step(rst_l, rx_en, b);
        check("model", 32'(dut_out()), 32'({m_valid, m_err, m_pid, m_seq, m_corr, m_dup}));
        if (pkt_valid === 1'b1) begin
            prev_pv = last_pv;
            last_pv = cyc_n;
        end
    endtask

    task automatic send_pkt(input logic [6:0] code);
        repeat (8) cyc(1'b1);
        for (int i = 6; i >= 0; i--) cyc(code[i]);
    endtask

    function automatic logic [6:0] encode(input bit p, input bit s);
        bit p1, p2, p4;
        p1 = p ^ s ^ ~s;
        p2 = p ^ ~p ^ ~s;
        p4 = s ^ ~p ^ ~s;
        return {p1, p2, p, p4, s, ~p, ~s};
    endfunction

    typedef struct {
        logic [6:0] code;
        logic [5:0] exp;
        string      nm;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // expected order: {valid, err, pid, seq, corrected, dup}
        vecs[0] = '{7'h19, 6'b101000, "ack_seq0"};
        vecs[1] = '{7'h66, 6'b100100, "ge_seq1"};
        vecs[2] = '{7'h66, 6'b100101, "ge_seq1_dup"};
        vecs[3] = '{7'h1D, 6'b101010, "corr_pos5"};
        vecs[4] = '{7'h33, 6'b011000, "compl_err"};
        vecs[5] = '{7'h26, 6'b100110, "corr_pos1"};
        vecs[6] = '{7'h19, 6'b101000, "ack_again"};

        rst_l = 1'b0;
        rx_en = 1'b0;
        serial_in = 1'b0;
        model_reset();
        cyc(1'b0);
        cyc(1'b0);
        check("reset_outputs", 32'(dut_out()), 32'h0);
        rst_l = 1'b1;
        rx_en = 1'b1;
        repeat (3) cyc(1'b0);

        for (int v = 0; v < 7; v++) begin
            send_pkt(vecs[v].code);
            check(vecs[v].nm, 32'(dut_out()), 32'(vecs[v].exp));
            cyc(1'b0);
            check({vecs[v].nm, "_deassert"}, 32'({pkt_valid, pkt_err}), 32'h0);
            cyc(1'b0);
        end

        // Seven 1s never sync; nine 1s frame one bit early (code 0x4C, complement error)
        repeat (4) cyc(1'b0);
        repeat (7) cyc(1'b1);
        repeat (5) cyc(1'b0);
        repeat (9) cyc(1'b1);
        cyc(1'b0); cyc(1'b0); cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);
        check("misaligned_err", 32'({pkt_valid, pkt_err}), 32'b01);
        cyc(1'b1);
        repeat (3) cyc(1'b0);

        // Async reset after three data bits
        repeat (8) cyc(1'b1);
        cyc(1'b0); cyc(1'b0); cyc(1'b1);
        rst_l = 1'b0;
        #1;
        model_reset();
        check("async_reset", 32'(dut_out()), 32'h0);
        cyc(1'b1); cyc(1'b0);
        rst_l = 1'b1;
        cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b0);
        check("no_pulse_after_reset", 32'({pkt_valid, pkt_err}), 32'h0);
        send_pkt(7'h19);
        check("post_reset_ack", 32'(dut_out()), 32'(6'b101000));
        cyc(1'b0);

        // rx_en dropped after four data bits
        repeat (8) cyc(1'b1);
        cyc(1'b0); cyc(1'b0); cyc(1'b1); cyc(1'b1);
        rx_en = 1'b0;
        cyc(1'b0); cyc(1'b0); cyc(1'b1);
        check("rx_en_abort", 32'({pkt_valid, pkt_err}), 32'h0);
        rx_en = 1'b1;
        repeat (2) cyc(1'b0);
        send_pkt(7'h19);
        check("rx_en_restore", 32'(dut_out()), 32'(6'b101001));

        // Back-to-back packets with no gap
        send_pkt(7'h66);
        send_pkt(7'h19);
        check("b2b_spacing", 32'(last_pv - prev_pv), 32'd15);
        repeat (2) cyc(1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 250; n++) begin
            int r;
            logic [6:0] code;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                #2;
                rst_l = 1'b0;
                #1;
                model_reset();
                check("rand_reset", 32'(dut_out()), 32'h0);
                cyc(1'b0);
                rst_l = 1'b1;
            end else if (r < 75) begin
                code = encode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                r = int'($urandom_range(0, 9));
                if (r < 4) code[$urandom_range(0, 6)] ^= 1'b1;
                if (r == 0) code[$urandom_range(0, 6)] ^= 1'b1;
                if (r == 9) code = 7'($urandom);
                for (int i = 0; i < 15; i++) begin
                    rx_en = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
                    cyc(i < 8 ? 1'b1 : code[14-i]);
                end
                rx_en = 1'b1;
                repeat ($urandom_range(0, 2)) cyc(1'b0);
            end else begin
                repeat ($urandom_range(1, 12)) cyc(1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hnd_pkt_receiver.md
Name: hnd_pkt_receiver

Overview:
- Serial receiver for TSPIN handshake packets (ACK / GE) on the single handshake wire.
- Hunts for the 8-bit syncword, then deserializes the 7-bit Hamming(7,4)-encoded header.
- Corrects single-bit errors and checks the pid/seqNum complement fields.
- Presents the decoded pid and sequence number, with duplicate detection, to the stop-and-wait send controller.

Parameters:
- SYNC_BITS, 8, syncword length.
- SYNCWORD, 8'hff, syncword value, matched MSB first.
- ENC_HEAD_BITS, 7, encoded header length; fixed at 7 for Hamming(7,4).

Ports:
- clk  in  1  system clock; all sampling on rising edge.
- rst_l  in  1  asynchronous active-low reset.
- rx_en  in  1  receiver enable; low forces HUNT and clears sync/shift registers.
- serial_in  in  1  handshake line, one bit per cycle, MSB first, idles at 0.
- pkt_valid  out  1  one-cycle pulse: a well-formed packet was decoded.
- pkt_err  out  1  one-cycle pulse: complement check failed (uncorrectable).
- pid  out  1  decoded pid (1 = ACK, 0 = GE); valid while pkt_valid is high, held otherwise.
- seq_num  out  1  decoded seqNum; valid while pkt_valid is high, held otherwise.
- corrected  out  1  high with pkt_valid/pkt_err if the syndrome was nonzero and one bit was flipped.
- seq_dup  out  1  high with pkt_valid if seq_num equals the last accepted seq_num.

Behaviour:
- Reset (async, rst_l=0):
  - state=HUNT; sync shift register=0; bit counter=0.
  - pkt_valid, pkt_err, pid, seq_num, corrected, seq_dup all 0.
  - last_seq=1, so the first seq 0 is not a duplicate.
  - Reset mid-packet discards the partial packet and produces no pulse.
- HUNT state:
  - Each cycle, shift serial_in into an 8-bit register (LSB in).
  - When {reg[6:0],serial_in}==SYNCWORD, go to DATA on that edge and set counter=0.
  - Longer runs of 1s match on the 8th; the next bit is data bit 1.
- DATA state:
  - Shift serial_in into a 7-bit code register; counter increments.
  - On the edge sampling the 7th bit (counter==6), decode combinationally on {code[5:0],serial_in}, register the results, return to HUNT with the sync register cleared to 0.
  - Latency: outputs valid in the cycle immediately after the 7th bit edge.
  - The bit on that following edge already enters the HUNT register, so back-to-back packets need no gap.
- Code layout:
  - Encoded bit at Hamming position k (1..7) is code[7-k]; position 1 is transmitted first.
  - Positions 1, 2, 4 are even parity p1, p2, p4.
  - Positions 3, 5, 6, 7 carry pid, seqNum, pid_n, seqNum_n respectively.
- Decode:
  - s1=x1^x3^x5^x7; s2=x2^x3^x6^x7; s4=x4^x5^x6^x7; syndrome={s4,s2,s1}.
  - Nonzero syndrome: flip position syndrome and set corrected=1.
  - After correction, if pid==~pid_n and seqNum==~seqNum_n: pkt_valid=1, pid/seq_num updated, seq_dup=(seqNum==last_seq), last_seq<=seqNum.
  - Otherwise: pkt_err=1, pid/seq_num/last_seq unchanged, seq_dup=0.
  - Double-bit errors are not distinguished; they surface as pkt_err or as a miscorrection.
- Pulses deassert the next cycle unless another packet completes (minimum packet spacing is 15 cycles, so pulses are never adjacent).
- rx_en low:
  - Takes effect on the next edge: state=HUNT, registers cleared, no pulse.
  - The pulse already in flight still completes.
  - last_seq, pid and seq_num are retained.

Test Plan:
- Reset, rx_en=1, send 8'hff then 7'h19 (0011001) -> one cycle after the last bit: pkt_valid=1, pid=1, seq_num=0, corrected=0, seq_dup=0.
- After the ACK seq 0 packet, send ff + 7'h66 -> pkt_valid, pid=0, seq_num=1, seq_dup=0. Then resend ff + 7'h66 -> pkt_valid, seq_dup=1.
- Send ff + 7'h1D (position 5 flipped in 0x19) -> syndrome 5, pkt_valid=1, pid=1, seq_num=0, corrected=1.
- Send ff + 7'h33 (valid codeword, pid=1, pid_n=1) -> pkt_err=1, pkt_valid=0, pid/seq_num hold previous values.
- Idle 0s, then 7'b1111111 (seven 1s) + 0s -> no sync, no pulse. Then nine 1s + 7'h19 (second bit of the code is 0, so it must shift) -> packet framed after the 8th 1, so the decoded code is 1 followed by 001100 = 7'h4C (not 0x19) -> misaligned frame, checked as pkt_err or miscorrection per the decode rules. Also assert rst_l=0 after 3 data bits -> no pulse, outputs 0, state HUNT.
- Send ff + 7'h19 with rx_en dropped after 4 data bits -> no pulse. Restore rx_en, send ff + 7'h19 -> normal pkt_valid. Send two packets back-to-back -> two pulses 15 cycles apart.
